// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//
// Execute-stage multiply/divide unit with the architectural HI/LO registers.
// A launch latches the operands and the operation. busy_o then stays high for
// MUL_LAT or DIV_LAT cycles. HI and LO are both written on the edge where
// busy_o falls. mthi/mtlo writes are accepted only while the unit is idle.
//
// Optional feature: define MDU_CANCEL_EN to add the cancel_i flush input.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-high reset
//   start_i   in   launch the operation selected by op_i
//   op_i      in   [2:0] 1=mult 2=multu 3=div 4=divu, 0=none
//   a_i       in   [31:0] rs operand; also the mthi/mtlo data
//   b_i       in   [31:0] rt operand
//   hlwe_i    in   mthi/mtlo write enable
//   hl_src_i  in   1=HI, 0=LO; selects the mt target and hl_o
//   cancel_i  in   (MDU_CANCEL_EN only) abort the running operation
//   hl_o      out  [31:0] HI or LO, selected by hl_src_i
//   hi_o      out  [31:0] HI register
//   lo_o      out  [31:0] LO register
//   busy_o    out  operation in flight (registered)
// ---------------------------------------------------------------------------
module mul_div_unit #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        hlwe_i,
    input  logic        hl_src_i,
`ifdef MDU_CANCEL_EN
    input  logic        cancel_i,
`endif
    output logic [31:0] hl_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_MUL  = 3'd1,
        OP_MULU = 3'd2,
        OP_DIV  = 3'd3,
        OP_DIVU = 3'd4
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    op_t               op_q;
    logic [31:0]       a_q;
    logic [31:0]       b_q;
    logic [31:0]       hi_q;
    logic [31:0]       lo_q;

    logic              cancel;
    logic              launch;
    logic              launch_mul;

`ifdef MDU_CANCEL_EN
    assign cancel = cancel_i;
`else
    assign cancel = 1'b0;
`endif

    assign launch     = start_i && (op_i >= 3'd1) && (op_i <= 3'd4);
    assign launch_mul = (op_i == 3'd1) || (op_i == 3'd2);

    // -----------------------------------------------------------------------
    // Result datapath, driven only by the latched operands.
    // -----------------------------------------------------------------------
    logic        is_signed;
    logic        a_neg;
    logic        b_neg;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] uquot;
    logic [31:0] urem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        res_hi    = '0;
        res_lo    = '0;
        is_signed = (op_q == OP_MUL) || (op_q == OP_DIV);
        a_neg     = is_signed && a_q[31];
        b_neg     = is_signed && b_q[31];

        // A sign-extended 64x64 product keeps the low 64 bits exact for the
        // signed case, so one multiplier serves mult and multu.
        mul_a   = {{32{a_neg}}, a_q};
        mul_b   = {{32{b_neg}}, b_q};
        product = mul_a * mul_b;

        // Signed divide runs on magnitudes, then fixes the signs: quotient
        // truncates toward zero, remainder follows the dividend. The
        // 0x80000000 / -1 case falls out as quotient 0x80000000, remainder 0.
        dvd   = a_neg ? (32'd0 - a_q) : a_q;
        dvs   = b_neg ? (32'd0 - b_q) : b_q;
        uquot = (dvs == 32'd0) ? 32'hFFFF_FFFF : (dvd / dvs);
        urem  = (dvs == 32'd0) ? dvd : (dvd % dvs);

        case (op_q)
            OP_MUL, OP_MULU: begin
                res_hi = product[63:32];
                res_lo = product[31:0];
            end
            OP_DIV, OP_DIVU: begin
                if (b_q == 32'd0) begin
                    res_hi = a_q;
                    res_lo = 32'hFFFF_FFFF;
                end else begin
                    res_lo = (a_neg ^ b_neg) ? (32'd0 - uquot) : uquot;
                    res_hi = a_neg ? (32'd0 - urem) : urem;
                end
            end
            default: begin
                res_hi = '0;
                res_lo = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Control FSM and architectural registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the values from before this edge.
        if (reset) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            cnt    <= '0;
            op_q   <= OP_NONE;
            a_q    <= '0;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cancel) begin
                        // A flush in the same cycle blocks a launch and an mt.
                    end else if (launch) begin
                        state  <= RUN;
                        busy_o <= 1'b1;
                        op_q   <= op_t'(op_i);
                        a_q    <= a_i;
                        b_q    <= b_i;
                        cnt    <= launch_mul ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
                    end else if (hlwe_i && !start_i) begin
                        // start_i has priority over a simultaneous mt.
                        if (hl_src_i) begin
                            hi_q <= a_i;
                        end else begin
                            lo_q <= a_i;
                        end
                    end
                end
                RUN: begin
                    if (cancel) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        cnt    <= '0;
                    end else if (cnt == CNT_W'(1)) begin
                        // Counter was loaded with the latency at launch; the
                        // value 1 marks the final edge of the operation.
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        cnt    <= '0;
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    cnt    <= '0;
                end
            endcase
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;
    assign hl_o = hl_src_i ? hi_q : lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
//
// Scoreboard bench for mul_div_unit. The driver pushes the expected HI/LO
// pair and busy length for every launch; a monitor pops and compares when
// busy_o falls. The reference model works on plain 64-bit integer arithmetic.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk;
    logic        reset;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        hlwe_i;
    logic        hl_src_i;
`ifdef MDU_CANCEL_EN
    logic        cancel_i;
`endif
    logic [31:0] hl_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy_o;

    mul_div_unit #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .hlwe_i   (hlwe_i),
        .hl_src_i (hl_src_i),
`ifdef MDU_CANCEL_EN
        .cancel_i (cancel_i),
`endif
        .hl_o     (hl_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o),
        .busy_o   (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;   // {HI, LO}
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    bit          abort_pending = 1'b0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural result from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] ua;
        logic [63:0] ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd1: return 64'(sa * sb);
            3'd2: return ua * ub;
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default: return {model_hi, model_lo};
        endcase
    endfunction

    // Monitor: compares on every falling busy_o.
    int busy_cnt  = 0;
    bit prev_busy = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            busy_cnt  = 0;
            prev_busy = 1'b0;
        end else begin
            if (busy_o) begin
                busy_cnt++;
            end else if (prev_busy) begin
                if (abort_pending) begin
                    abort_pending = 1'b0;
                end else if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_completion: hi=%h lo=%h with empty scoreboard", hi_o, lo_o);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("busy_len", 64'(busy_cnt), 64'(e.lat));
                    check("hi_result", 64'(hi_o), 64'(e.res[63:32]));
                    check("lo_result", 64'(lo_o), 64'(e.res[31:0]));
                end
                busy_cnt = 0;
            end
            prev_busy = busy_o;
        end
    end

    // Present a launch for one edge; returns at launch edge + 1.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.res = ref_result(op, a, b);
        e.lat = (op <= 3'd2) ? MUL_LAT : DIV_LAT;
        sb_q.push_back(e);
        model_hi = e.res[63:32];
        model_lo = e.res[31:0];
        start_i  = 1'b1;
        op_i     = op;
        a_i      = a;
        b_i      = b;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        op_i    = 3'd0;
        a_i     = $urandom;
        b_i     = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy_o) begin
            checks++;
            failures++;
            $display("FAIL busy_timeout: busy_o still 1 after %0d cycles", n);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b);
        wait_idle();
    endtask

    task automatic mt(input logic sel, input logic [31:0] val);
        hlwe_i   = 1'b1;
        hl_src_i = sel;
        a_i      = val;
        @(posedge clk);
        #1;
        hlwe_i = 1'b0;
        if (sel) model_hi = val; else model_lo = val;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_hi"}, 64'(hi_o), 64'(model_hi));
        check({tag, "_lo"}, 64'(lo_o), 64'(model_lo));
        hl_src_i = 1'b1;
        #1;
        check({tag, "_hl_hi"}, 64'(hl_o), 64'(model_hi));
        hl_src_i = 1'b0;
        #1;
        check({tag, "_hl_lo"}, 64'(hl_o), 64'(model_lo));
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;

        reset    = 1'b1;
        start_i  = 1'b0;
        op_i     = 3'd0;
        a_i      = '0;
        b_i      = '0;
        hlwe_i   = 1'b0;
        hl_src_i = 1'b0;
`ifdef MDU_CANCEL_EN
        cancel_i = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_busy", 64'(busy_o), 64'd0);
        check_regs("reset");

        // Directed cases from the operational rules.
        run_op(3'd1, 32'hFFFF_FFFD, 32'd5);
        check_regs("mult_neg3x5");
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2);
        check_regs("multu");
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2);
        check_regs("div_neg7_2");
        run_op(3'd4, 32'd7, 32'd0);
        check_regs("divu_by_zero");
        run_op(3'd3, 32'hFFFF_FFF0, 32'd0);
        check_regs("div_by_zero");
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check_regs("div_overflow");
        run_op(3'd3, 32'd7, 32'hFFFF_FFFE);
        check_regs("div_7_neg2");

        mt(1'b1, 32'h1234);
        check_regs("mthi");
        mt(1'b0, 32'hCAFE);
        check_regs("mtlo");

        // start_i with op 0 is ignored.
        start_i = 1'b1;
        op_i    = 3'd0;
        a_i     = 32'hDEAD;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        check("op0_busy", 64'(busy_o), 64'd0);
        check_regs("op0_ignored");

        // mtlo while running is ignored; the result still lands.
        prev_lo = model_lo;
        issue(3'd2, 32'd9, 32'd11);
        hlwe_i   = 1'b1;
        hl_src_i = 1'b0;
        a_i      = 32'h55;
        @(posedge clk);
        #1;
        hlwe_i = 1'b0;
        check("mt_in_run_lo_held", 64'(lo_o), 64'(prev_lo));
        wait_idle();
        check_regs("mt_in_run");

        // start and hlwe together in idle: start wins.
        hlwe_i   = 1'b1;
        hl_src_i = 1'b1;
        issue(3'd1, 32'd6, 32'd7);
        hlwe_i = 1'b0;
        wait_idle();
        check_regs("start_beats_mt");

        // Back-to-back launches, the first cycle after busy falls.
        issue(3'd4, 32'd100, 32'd7);
        wait_idle();
        issue(3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        wait_idle();
        check_regs("back_to_back");

        // Reset in cycle 2 of a mult.
        issue(3'd1, 32'd3, 32'd4);
        @(posedge clk);
        #1;
        reset = 1'b1;
        sb_q.delete();
        model_hi = '0;
        model_lo = '0;
        #1;
        check("reset_mid_busy", 64'(busy_o), 64'd0);
        check_regs("reset_mid");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("after_reset_busy", 64'(busy_o), 64'd0);
        check_regs("after_reset");

`ifdef MDU_CANCEL_EN
        // Cancel in cycle 3 of a div keeps the prior HI/LO.
        mt(1'b1, 32'hA1);
        mt(1'b0, 32'hB2);
        prev_hi = model_hi;
        prev_lo = model_lo;
        issue(3'd3, 32'd50, 32'd3);
        @(posedge clk);
        #1;
        cancel_i      = 1'b1;
        abort_pending = 1'b1;
        void'(sb_q.pop_back());
        model_hi = prev_hi;
        model_lo = prev_lo;
        @(posedge clk);
        #1;
        cancel_i = 1'b0;
        check("cancel_busy", 64'(busy_o), 64'd0);
        check_regs("cancel");
`endif

        // Randomized mix of operations and mt writes.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                mt(1'($urandom_range(0, 1)), $urandom);
            end else begin
                run_op(3'($urandom_range(1, 4)), rand_operand(), rand_operand());
            end
            check_regs("random");
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
